// File: rtl/srp_tsync_pkg.sv
// Shared constants and grant encoding for the SRP time synchronizer sample store.
// Also imported by the correlator, so keep it free of arbiter-private detail.
package srp_tsync_pkg;

    localparam int unsigned SRP_DEPTH = 2097;
    localparam int unsigned SRP_AW    = 12;
    localparam int unsigned SRP_DW    = 32;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WR   = 2'd1,
        GNT_RD   = 2'd2
    } gnt_e;

endpackage

// File: rtl/srp_rr_arb2.sv
// Two-input round-robin arbiter: a lone requester wins, a tie goes to the side
// not granted last. The last-grant flop moves only on an actual grant.
module srp_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    // last_q: 0 = requester 0 was granted last, 1 = requester 1
    logic last_q;
    logic last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        gnt_o  = 2'b00;
        last_d = last_q;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
        if (gnt_o[0]) begin
            last_d = 1'b0;
        end else if (gnt_o[1]) begin
            last_d = 1'b1;
        end
    end

endmodule

// File: rtl/srp_bram_arbiter.sv
// Shares the single-port sample BRAM between the capture stream (circular history
// writer) and the correlator (reads samples by age, 0 = newest).
module srp_bram_arbiter
    import srp_tsync_pkg::*;
#(
    parameter int unsigned DEPTH = SRP_DEPTH,
    parameter int unsigned AW    = SRP_AW,
    parameter int unsigned DW    = SRP_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          freeze,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_offset,
    output logic          rd_gnt,
    output logic          rd_valid,
    output logic          rd_err,
    output logic [DW-1:0] rd_data,
    output logic [AW-1:0] fill_count,
    output logic          full,
    output logic          bram_en,
    output logic          bram_we,
    output logic [AW-1:0] bram_addr,
    output logic [DW-1:0] bram_di,
    input  logic [DW-1:0] bram_dout
);

    logic          wr_req_c;
    logic          rd_req_c;
    logic [1:0]    arb_gnt;
    gnt_e          sel_c;
    logic          rd_ok_c;
    logic [AW:0]   diff_c;
    logic [AW-1:0] rd_addr_c;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] fill_q,   fill_d;
    logic          full_q,   full_d;
    logic [AW-1:0] addr_q;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_err_q,   rd_err_d;

    // clear outranks both requesters and freeze only gates the writer
    assign wr_req_c = s_valid & ~freeze & ~clear;
    assign rd_req_c = rd_req & ~clear;

    srp_rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i ({rd_req_c, wr_req_c}),
        .gnt_o (arb_gnt)
    );

    always_comb begin
        sel_c = GNT_NONE;
        if (rst_n && arb_gnt[0]) begin
            sel_c = GNT_WR;
        end else if (rst_n && arb_gnt[1]) begin
            sel_c = GNT_RD;
        end
    end

    // Age-to-address: (wr_ptr-1-offset) mod DEPTH; one extra bit flags underflow
    assign diff_c    = {1'b0, wr_ptr_q} - (AW+1)'(1) - {1'b0, rd_offset};
    assign rd_addr_c = diff_c[AW] ? AW'(diff_c + (AW+1)'(DEPTH)) : diff_c[AW-1:0];
    // fill_count never exceeds DEPTH, so this also rejects offsets >= DEPTH
    assign rd_ok_c   = (rd_offset < fill_q);

    always_comb begin
        s_ready   = 1'b0;
        rd_gnt    = 1'b0;
        bram_en   = 1'b0;
        bram_we   = 1'b0;
        bram_addr = addr_q;
        unique case (sel_c)
            GNT_WR: begin
                s_ready   = 1'b1;
                bram_en   = 1'b1;
                bram_we   = 1'b1;
                bram_addr = wr_ptr_q;
            end
            GNT_RD: begin
                rd_gnt = 1'b1;
                if (rd_ok_c) begin
                    bram_en   = 1'b1;
                    bram_addr = rd_addr_c;
                end
            end
            default: ;
        endcase
    end

    assign bram_di = s_data;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        fill_d     = fill_q;
        rd_valid_d = (sel_c == GNT_RD);
        rd_err_d   = (sel_c == GNT_RD) & ~rd_ok_c;
        if (clear) begin
            wr_ptr_d = '0;
            fill_d   = '0;
        end else if (sel_c == GNT_WR) begin
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
            if (fill_q != AW'(DEPTH)) begin
                fill_d = fill_q + AW'(1);
            end
        end
        full_d = (fill_d == AW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            full_q     <= 1'b0;
            addr_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            fill_q     <= fill_d;
            full_q     <= full_d;
            addr_q     <= bram_addr;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
        end
    end

    // BRAM dout arrives the cycle after the read, alongside rd_valid
    assign rd_data    = (rd_valid_q && !rd_err_q) ? bram_dout : '0;
    assign rd_valid   = rd_valid_q;
    assign rd_err     = rd_err_q;
    assign fill_count = fill_q;
    assign full       = full_q;

endmodule
